reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 17 +
 rtl/reg_dump.sv | 110 +++++++++++
 tb/tb_reg_dump.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_pkg.sv
// Shared CPU constants and the register-dump FSM state type.
package reg_dump_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [7:0]  DUMP_HDR   = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LOAD,
      SEND,
      DONE
   } dump_state_t;

endpackage

// File: rtl/reg_dump.sv
// Streams a header byte followed by every register, little-endian,
// over a valid/ready byte interface.
module reg_dump #(
   parameter int unsigned XLEN     = reg_dump_pkg::XLEN,
   parameter int unsigned NUM_REGS = reg_dump_pkg::NUM_REGS,
   parameter logic [7:0]  HDR_BYTE = reg_dump_pkg::DUMP_HDR
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   output logic [reg_dump_pkg::REG_ADDR_W-1:0] rd_addr,
   input  logic [XLEN-1:0]                     rd_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [7:0]                          out_data,
   output logic                                out_last,
   output logic                                busy,
   output logic                                done
);

   import reg_dump_pkg::*;

   localparam int unsigned BYTES  = XLEN / 8;
   localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BIDX_W-1:0]     LAST_B   = BIDX_W'(BYTES - 1);
   localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

   dump_state_t             state;
   logic [REG_ADDR_W-1:0]   reg_idx;
   logic [BIDX_W-1:0]       byte_idx;
   logic [XLEN-1:0]         word;

   logic                    last_reg;
   logic                    last_byte;
   logic [BIDX_W-1:0]       byte_nxt;

   assign last_reg  = (reg_idx == LAST_REG);
   assign last_byte = (byte_idx == LAST_B);
   assign byte_nxt  = byte_idx + BIDX_W'(1);
   assign rd_addr   = reg_idx;

   // Outputs are updated on the transition into the state that presents them,
   // so out_data/out_last stay frozen while the sink stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         reg_idx   <= '0;
         byte_idx  <= '0;
         word      <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= HDR;
                  reg_idx   <= '0;
                  out_valid <= 1'b1;
                  out_data  <= HDR_BYTE;
                  out_last  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            HDR: begin
               if (out_ready) begin
                  state     <= LOAD;
                  out_valid <= 1'b0;
               end
            end
            LOAD: begin
               word      <= rd_data;
               byte_idx  <= '0;
               out_data  <= rd_data[7:0];
               out_last  <= last_reg && (BYTES == 1);
               out_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  if (!last_byte) begin
                     byte_idx <= byte_nxt;
                     out_data <= 8'(word >> (8 * byte_nxt));
                     out_last <= last_reg && (byte_nxt == LAST_B);
                  end else if (!last_reg) begin
                     reg_idx   <= reg_idx + REG_ADDR_W'(1);
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= LOAD;
                  end else begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a frame model feeds an expected-byte queue
// that a negedge monitor drains on every handshake.
module tb_reg_dump;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NB   = XLEN / 8;
   localparam logic [7:0]  HDR  = 8'hA5;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rd_data;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [7:0]      out_data;
   logic            out_last;
   logic            busy;
   logic            done;

   logic [XLEN-1:0] rf [NREG];
   beat_t           exp_q [$];
   int              tests = 0;
   int              fails = 0;
   int              done_seen = 0;
   int              frames_done = 0;
   int              rmode = 0;

   reg_dump dut (
      .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   assign rd_data = rf[rd_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sink readiness: 0 always, 1 alternate, 2 random, 3 stalled.
   always @(posedge clk) begin
      #2;
      case (rmode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   logic       stall_p = 1'b0;
   logic       done_p = 1'b0;
   logic [7:0] d_p = '0;
   logic       l_p = 1'b0;
   beat_t      e;

   always @(negedge clk) begin
      if (reset) begin
         stall_p = 1'b0;
         done_p  = 1'b0;
      end else begin
         if (stall_p) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(d_p));
            chk("hold_last", 32'(out_last), 32'(l_p));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_byte: got %02h with nothing expected at %0t", out_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("byte", 32'(out_data), 32'(e.d));
               chk("last", 32'(out_last), 32'(e.l));
            end
         end
         if (done) begin
            done_seen++;
            chk("done_width", 32'(done_p), 32'd0);
         end
         done_p  = done;
         stall_p = out_valid && !out_ready;
         d_p     = out_data;
         l_p     = out_last;
      end
   end

   task automatic set_pattern();
      for (int i = 0; i < int'(NREG); i++) rf[i] = '0;
      rf[1] = 32'h05; rf[2] = 32'h0A; rf[3] = 32'h0F; rf[4] = 32'h05;
      rf[5] = 32'h0F; rf[6] = 32'h0A; rf[7] = 32'h1E; rf[8] = 32'h03;
   endtask

   task automatic set_random();
      for (int i = 0; i < int'(NREG); i++) rf[i] = $urandom;
   endtask

   // Expected frame: header, then each register low byte first.
   task automatic push_frame();
      beat_t b;
      b.d = HDR;
      b.l = 1'b0;
      exp_q.push_back(b);
      for (int r = 0; r < int'(NREG); r++)
         for (int k = 0; k < int'(NB); k++) begin
            b.d = 8'(rf[r] >> (8 * k));
            b.l = (r == int'(NREG) - 1) && (k == int'(NB) - 1);
            exp_q.push_back(b);
         end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 3000) begin
         cycle();
         cyc++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done after %0d cycles", cyc);
      end
   endtask

   task automatic wait_send(input int r);
      int n = 0;
      while (!(int'(rd_addr) == r && out_valid) && n < 3000) begin
         cycle();
         n++;
      end
      chk("reach_reg", 32'(rd_addr), 32'(r));
   endtask

   task automatic finish_frame();
      int cyc;
      wait_done(cyc);
      chk("busy_in_done", 32'(busy), 32'd1);
      frames_done++;
      cycle();
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int cyc;
      set_pattern();
      repeat (3) cycle();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      reset = 1'b0;
      rmode = 0;
      repeat (2) cycle();

      // Full-rate frame with timing checks.
      push_frame();
      pulse_start();
      chk("hdr_valid", 32'(out_valid), 32'd1);
      chk("hdr_data", 32'(out_data), 32'(HDR));
      chk("hdr_busy", 32'(busy), 32'd1);
      wait_done(cyc);
      chk("done_latency", 32'(cyc), 32'd161);
      chk("busy_in_done", 32'(busy), 32'd1);
      frames_done++;
      cycle();
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      // Alternating ready.
      rmode = 1;
      repeat (2) cycle();
      push_frame();
      pulse_start();
      finish_frame();

      // Long header stall.
      rmode = 3;
      repeat (2) cycle();
      push_frame();
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_data", 32'(out_data), 32'(HDR));
         chk("stall_addr", 32'(rd_addr), 32'd0);
         cycle();
      end
      rmode = 0;
      finish_frame();

      // x2 rewritten after it has been latched.
      rmode = 2;
      repeat (2) cycle();
      push_frame();
      pulse_start();
      wait_send(2);
      rf[2] = 32'hFF;
      finish_frame();
      rf[2] = 32'h0A;

      // Start re-pulsed in HDR and in SEND.
      set_random();
      rmode = 3;
      repeat (2) cycle();
      push_frame();
      pulse_start();
      pulse_start();
      rmode = 2;
      wait_send(5);
      pulse_start();
      finish_frame();
      repeat (10) cycle();
      chk("no_queue_busy", 32'(busy), 32'd0);
      chk("no_queue_valid", 32'(out_valid), 32'd0);

      // Start held across the last byte and the DONE cycle.
      rmode = 0;
      repeat (2) cycle();
      push_frame();
      pulse_start();
      cyc = 0;
      while (!(out_valid && out_last) && cyc < 3000) begin
         cycle();
         cyc++;
      end
      chk("saw_last", 32'(out_last), 32'd1);
      start = 1'b1;
      cycle();
      chk("done_cycle", 32'(done), 32'd1);
      frames_done++;
      cycle();
      start = 1'b0;
      chk("idle_after_done", 32'(busy), 32'd0);
      repeat (10) cycle();
      chk("no_frame_busy", 32'(busy), 32'd0);
      chk("no_frame_queue", 32'(exp_q.size()), 32'd0);

      // Abort with reset during reg 3.
      rmode = 2;
      repeat (2) cycle();
      push_frame();
      pulse_start();
      wait_send(3);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      exp_q.delete();
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_addr", 32'(rd_addr), 32'd0);
      chk("abort_last", 32'(out_last), 32'd0);
      repeat (3) cycle();
      chk("abort_no_resume", 32'(out_valid), 32'd0);
      rmode = 0;
      set_pattern();
      push_frame();
      pulse_start();
      chk("restart_hdr", 32'(out_data), 32'(HDR));
      finish_frame();

      // Random contents and random back-pressure.
      for (int f = 0; f < 4; f++) begin
         set_random();
         rmode = int'($urandom_range(0, 2));
         repeat (2) cycle();
         push_frame();
         pulse_start();
         finish_frame();
      end

      repeat (3) cycle();
      chk("done_count", 32'(done_seen), 32'(frames_done));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
